// File: rtl/cia_sdr_fifo.sv
// cia_sdr_fifo -- 8520-style serial data register with TX and RX word FIFOs.
//
// Output mode (spmode=1): words written to the SDR queue in the TX FIFO and
// are shifted out MSB first on sp_out.  cnt_out toggles once per timer A
// underflow, so one bit takes two underflows.  Input mode (spmode=0): bits
// on sp_in are captured on rising edges of the synchronised cnt_in and
// complete words are queued in the RX FIFO.  ser pulses for one clk7_en
// cycle per completed word in either direction.
//
// Bus handshake: wr and rd are level strobes qualified by sdr_sel or
// stat_sel.  A write acts once, on the first clk7_en cycle of its strobe.
// A read shows the RX head combinationally and pops when the strobe falls.
//
// Optional build macro CIA_SDR_STATUS_EN adds a status register
// {ovr, tx_full, tx_empty, rx_full, rx_empty, busy} on stat_sel reads and
// the sticky overrun flag behind it.  Without it stat_sel reads as zero.
module cia_sdr_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clk7_en,
    input  logic          sdr_sel,
    input  logic          stat_sel,
    input  logic          wr,
    input  logic          rd,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    input  logic          spmode,
    input  logic          tmra_ovf,
    input  logic          sp_in,
    input  logic          cnt_in,
    output logic          sp_out,
    output logic          cnt_out,
    output logic          ser
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DW + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DW);
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

    // bus strobes and their one-cycle history
    logic wr_req, rd_req, st_req;
    logic wr_req_d, rd_req_d, spmode_d;

    // input synchronisers
    logic [1:0] sp_sync, cnt_sync;
    logic       cnt_prev, rx_edge;

    // FIFO state
    logic [DW-1:0] tx_mem [DEPTH];
    logic [DW-1:0] rx_mem [DEPTH];
    logic [AW:0]   tx_wp, tx_rp, rx_wp, rx_rp;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic [DW-1:0] last_rx;

    // shifter state
    logic          busy;
    logic [DW-1:0] shreg;
    logic [CW-1:0] bitcnt;

    // per-cycle control
    logic          mode_chg;
    logic          tx_push, tx_step, tx_done, tx_load;
    logic          rx_step, rx_done, rx_push, rx_pop;
    logic [DW-1:0] rx_word;
    logic [DW-1:0] status_word;

    assign wr_req = wr & sdr_sel;
    assign rd_req = rd & sdr_sel & ~wr;
    assign st_req = rd & stat_sel & ~wr;

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);

    assign mode_chg = clk7_en & (spmode != spmode_d);
    assign rx_edge  = cnt_sync[1] & ~cnt_prev;

    assign tx_push = clk7_en & wr_req & ~wr_req_d & spmode & ~tx_full;
    assign rx_push = rx_done & ~rx_full;
    assign rx_pop  = clk7_en & rd_req_d & ~rd_req & ~rx_empty;

    // Shifter sequencing: what happens to the shifter this cycle
    always_comb begin
        tx_step = 1'b0;
        tx_done = 1'b0;
        tx_load = 1'b0;
        rx_step = 1'b0;
        rx_done = 1'b0;
        rx_word = DW'({shreg, sp_sync[1]});
        if (clk7_en && !mode_chg) begin
            if (spmode) begin
                tx_step = busy & tmra_ovf;
                // last rising toggle of the word; the next word loads alongside
                tx_done = tx_step & ~cnt_out & (bitcnt == CNT_ONE);
                tx_load = ~tx_empty & (~busy | tx_done);
            end else begin
                rx_step = rx_edge;
                rx_done = rx_edge & (bitcnt == CNT_LAST);
            end
        end
    end

    // Strobe edge detection and mode history, advanced on clk7_en
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_req_d <= 1'b0;
            rd_req_d <= 1'b0;
            // start level-matched so leaving reset is not seen as a mode change
            spmode_d <= spmode;
        end else if (clk7_en) begin
            wr_req_d <= wr_req;
            rd_req_d <= rd_req;
            spmode_d <= spmode;
        end
    end

    // Double synchronisers for the external serial pair, idle high
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_sync  <= 2'b11;
            cnt_sync <= 2'b11;
            cnt_prev <= 1'b1;
        end else if (clk7_en) begin
            sp_sync  <= {sp_sync[0], sp_in};
            cnt_sync <= {cnt_sync[0], cnt_in};
            cnt_prev <= cnt_sync[1];
        end
    end

    // TX FIFO pointers: pushed from the bus, popped by the shifter load
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + PTR_ONE;
            if (tx_load) tx_rp <= tx_rp + PTR_ONE;
        end
    end

    // TX FIFO storage
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= data_in;
    end

    // RX FIFO pointers and the last-read word
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wp   <= '0;
            rx_rp   <= '0;
            last_rx <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + PTR_ONE;
            if (rx_pop) begin
                rx_rp   <= rx_rp + PTR_ONE;
                last_rx <= rx_mem[rx_rp[AW-1:0]];
            end
        end
    end

    // RX FIFO storage
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_word;
    end

    // Shift register, bit counter, serial outputs and the word-complete pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            shreg   <= '0;
            bitcnt  <= '0;
            cnt_out <= 1'b1;
            sp_out  <= 1'b1;
            ser     <= 1'b0;
        end else if (clk7_en) begin
            ser <= tx_done | rx_done;
            if (mode_chg) begin
                // abandon the word in flight; queued words stay queued
                busy    <= 1'b0;
                shreg   <= '0;
                bitcnt  <= '0;
                cnt_out <= 1'b1;
                sp_out  <= 1'b1;
            end else if (spmode) begin
                if (tx_load) begin
                    busy    <= 1'b1;
                    shreg   <= tx_mem[tx_rp[AW-1:0]];
                    bitcnt  <= CNT_FULL;
                    cnt_out <= 1'b1;
                end else if (tx_done) begin
                    busy    <= 1'b0;
                    bitcnt  <= '0;
                    cnt_out <= 1'b1;
                end else if (tx_step) begin
                    cnt_out <= ~cnt_out;
                    if (cnt_out) begin
                        // falling toggle presents the next bit
                        sp_out <= shreg[DW-1];
                        shreg  <= shreg << 1;
                    end else begin
                        bitcnt <= bitcnt - CNT_ONE;
                    end
                end
            end else begin
                busy    <= 1'b0;
                cnt_out <= 1'b1;
                sp_out  <= 1'b1;
                if (rx_done) begin
                    shreg  <= rx_word;
                    bitcnt <= '0;
                end else if (rx_step) begin
                    shreg  <= rx_word;
                    bitcnt <= bitcnt + CNT_ONE;
                end
            end
        end
    end

`ifdef CIA_SDR_STATUS_EN
    logic ovr, st_req_d, busy_any, tx_drop, rx_drop;

    assign busy_any = busy | (bitcnt != '0);
    assign tx_drop  = clk7_en & wr_req & ~wr_req_d & spmode & tx_full;
    assign rx_drop  = rx_done & rx_full;

    // Sticky overrun: set by a dropped word, cleared when a status read ends
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr      <= 1'b0;
            st_req_d <= 1'b0;
        end else if (clk7_en) begin
            st_req_d <= st_req;
            if (tx_drop || rx_drop) ovr <= 1'b1;
            else if (st_req_d && !st_req) ovr <= 1'b0;
        end
    end

    assign status_word = DW'({ovr, tx_full, tx_empty, rx_full, rx_empty, busy_any});
`else
    assign status_word = '0;
`endif

    // Read data mux: RX head (or last word read), status, otherwise zero
    always_comb begin
        data_out = '0;
        if (rd_req) data_out = rx_empty ? last_rx : rx_mem[rx_rp[AW-1:0]];
        else if (st_req) data_out = status_word;
    end

endmodule

// File: tb/tb_cia_sdr_fifo.sv
// Directed bench for cia_sdr_fifo (DW=8, DEPTH=4, clk7_en held high).
// Status constants follow CIA_SDR_STATUS_EN: bit5 ovr, bit4 tx_full,
// bit3 tx_empty, bit2 rx_full, bit1 rx_empty, bit0 busy; all zero without it.
module tb_cia_sdr_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

`ifdef CIA_SDR_STATUS_EN
    localparam logic [DW-1:0] ST_IDLE    = 8'h0A;
    localparam logic [DW-1:0] ST_TXF     = 8'h13;
    localparam logic [DW-1:0] ST_TXF_OVR = 8'h33;
    localparam logic [DW-1:0] ST_RXF_OVR = 8'h2C;
`else
    localparam logic [DW-1:0] ST_IDLE    = 8'h00;
    localparam logic [DW-1:0] ST_TXF     = 8'h00;
    localparam logic [DW-1:0] ST_TXF_OVR = 8'h00;
    localparam logic [DW-1:0] ST_RXF_OVR = 8'h00;
`endif

    logic          clk = 1'b0;
    logic          reset, clk7_en, sdr_sel, stat_sel, wr, rd;
    logic [DW-1:0] data_in, data_out;
    logic          spmode, tmra_ovf, sp_in, cnt_in;
    logic          sp_out, cnt_out, ser;

    int   errors = 0;
    int   checks = 0;
    int   ser_count = 0;
    logic cap_q[$];
    logic cnt_prev_tb = 1'b1;

    cia_sdr_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .clk7_en  (clk7_en),
        .sdr_sel  (sdr_sel),
        .stat_sel (stat_sel),
        .wr       (wr),
        .rd       (rd),
        .data_in  (data_in),
        .data_out (data_out),
        .spmode   (spmode),
        .tmra_ovf (tmra_ovf),
        .sp_in    (sp_in),
        .cnt_in   (cnt_in),
        .sp_out   (sp_out),
        .cnt_out  (cnt_out),
        .ser      (ser)
    );

    // clock
    always #5 clk = ~clk;

    // monitor: sp_out at each cnt_out rise, and ser pulse count
    always @(negedge clk) begin
        if (cnt_out && !cnt_prev_tb) cap_q.push_back(sp_out);
        cnt_prev_tb = cnt_out;
        if (ser === 1'b1) ser_count++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // rebuild a word from DW captured bits, MSB first
    task automatic check_word(input string tag, input int base, input logic [DW-1:0] exp);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < DW; i++)
            w = {w[DW-2:0], (base + i < cap_q.size()) ? cap_q[base + i] : 1'bx};
        check(tag, 32'(w), 32'(exp));
    endtask

    task automatic ovf(input int n);
        repeat (n) begin
            tmra_ovf = 1'b1;
            tick();
            tmra_ovf = 1'b0;
            tick();
        end
    endtask

    task automatic sdr_write(input logic [DW-1:0] d);
        sdr_sel = 1'b1;
        wr      = 1'b1;
        data_in = d;
        tick();
        sdr_sel = 1'b0;
        wr      = 1'b0;
        tick();
    endtask

    task automatic sdr_read(output logic [DW-1:0] d);
        sdr_sel = 1'b1;
        rd      = 1'b1;
        #1;
        d = data_out;
        tick();
        sdr_sel = 1'b0;
        rd      = 1'b0;
        tick();
    endtask

    task automatic stat_read(output logic [DW-1:0] d);
        stat_sel = 1'b1;
        rd       = 1'b1;
        #1;
        d = data_out;
        tick();
        stat_sel = 1'b0;
        rd       = 1'b0;
        tick();
    endtask

    task automatic rx_bit(input logic b);
        sp_in  = b;
        cnt_in = 1'b0;
        tick(3);
        cnt_in = 1'b1;
        tick(3);
    endtask

    task automatic rx_word(input logic [DW-1:0] w);
        for (int i = DW - 1; i >= 0; i--) rx_bit(w[i]);
    endtask

    initial begin
        logic [DW-1:0] d;
        int base;
        int sbase;

        // reset
        reset = 1'b1; clk7_en = 1'b1; sdr_sel = 1'b0; stat_sel = 1'b0;
        wr = 1'b0; rd = 1'b0; data_in = '0; spmode = 1'b0;
        tmra_ovf = 1'b0; sp_in = 1'b1; cnt_in = 1'b1;
        tick(3);
        reset = 1'b0;
        tick();
        check("rst_sp_out", 32'(sp_out), 32'd1);
        check("rst_cnt_out", 32'(cnt_out), 32'd1);
        check("rst_ser", 32'(ser), 32'd0);
        check("rst_data_idle", 32'(data_out), 32'd0);
        sdr_read(d);
        check("rst_sdr_read", 32'(d), 32'd0);
        stat_read(d);
        check("rst_status", 32'(d), 32'(ST_IDLE));

        // single word out: 0xA5 over 16 underflows
        spmode = 1'b1;
        tick(2);
        sdr_write(8'hA5);
        base  = cap_q.size();
        sbase = ser_count;
        ovf(16);
        check("t1_rises", 32'(cap_q.size() - base), 32'd8);
        check_word("t1_bits", base, 8'hA5);
        check("t1_ser", 32'(ser_count - sbase), 32'd1);
        check("t1_cnt_end", 32'(cnt_out), 32'd1);

        // TX fill: 5 writes while idle, 6th dropped
        sdr_write(8'h11);
        sdr_write(8'h22);
        sdr_write(8'h33);
        sdr_write(8'h44);
        sdr_write(8'h55);
        stat_read(d);
        check("t2_status_full", 32'(d), 32'(ST_TXF));
        sdr_write(8'h66);
        stat_read(d);
        check("t2_status_ovr", 32'(d), 32'(ST_TXF_OVR));
        stat_read(d);
        check("t2_status_clr", 32'(d), 32'(ST_TXF));
        base  = cap_q.size();
        sbase = ser_count;
        ovf(5 * 16);
        check_word("t2_w0", base, 8'h11);
        check_word("t2_w1", base + 8, 8'h22);
        check_word("t2_w2", base + 16, 8'h33);
        check_word("t2_w3", base + 24, 8'h44);
        check_word("t2_w4", base + 32, 8'h55);
        check("t2_rises", 32'(cap_q.size() - base), 32'd40);
        check("t2_ser", 32'(ser_count - sbase), 32'd5);
        stat_read(d);
        check("t2_status_idle", 32'(d), 32'(ST_IDLE));

        // abort after 3 bits of 0xFF, then resume with the queued 0x81
        sdr_write(8'hFF);
        sdr_write(8'h81);
        sbase = ser_count;
        ovf(7);
        check("ab_cnt_low", 32'(cnt_out), 32'd0);
        spmode = 1'b0;
        tick();
        check("ab_cnt_out", 32'(cnt_out), 32'd1);
        check("ab_sp_out", 32'(sp_out), 32'd1);
        tick(2);
        check("ab_no_ser", 32'(ser_count - sbase), 32'd0);
        spmode = 1'b1;
        tick(2);
        base  = cap_q.size();
        sbase = ser_count;
        ovf(16);
        check_word("ab_resume", base, 8'h81);
        check("ab_resume_ser", 32'(ser_count - sbase), 32'd1);

        // reset during bit 4 of 0xA5 with 0x3C queued
        sdr_write(8'hA5);
        sdr_write(8'h3C);
        ovf(7);
        check("rm_cnt_pre", 32'(cnt_out), 32'd0);
        check("rm_sp_pre", 32'(sp_out), 32'd0);
        sbase = ser_count;
        reset = 1'b1;
        tick();
        check("rm_sp_out", 32'(sp_out), 32'd1);
        check("rm_cnt_out", 32'(cnt_out), 32'd1);
        check("rm_ser", 32'(ser), 32'd0);
        reset = 1'b0;
        tick();
        ovf(4);
        check("rm_cnt_idle", 32'(cnt_out), 32'd1);
        check("rm_no_ser", 32'(ser_count - sbase), 32'd0);
        stat_read(d);
        check("rm_status", 32'(d), 32'(ST_IDLE));
        sdr_read(d);
        check("rm_last_rx", 32'(d), 32'd0);

        // input mode: 0x3C then 0xC3
        spmode = 1'b0;
        tick(2);
        sbase = ser_count;
        rx_word(8'h3C);
        rx_word(8'hC3);
        tick(2);
        check("in_ser", 32'(ser_count - sbase), 32'd2);
        check("in_cnt_out", 32'(cnt_out), 32'd1);
        check("in_data_idle", 32'(data_out), 32'd0);
        sdr_read(d);
        check("in_rd0", 32'(d), 32'h3C);
        sdr_read(d);
        check("in_rd1", 32'(d), 32'hC3);
        sdr_read(d);
        check("in_rd_last", 32'(d), 32'hC3);
        sdr_read(d);
        check("in_rd_last2", 32'(d), 32'hC3);

        // input overrun: 5 words, no reads
        sbase = ser_count;
        rx_word(8'h01);
        rx_word(8'h02);
        rx_word(8'h04);
        rx_word(8'h08);
        rx_word(8'h10);
        tick(2);
        check("ov_ser", 32'(ser_count - sbase), 32'd5);
        stat_read(d);
        check("ov_status", 32'(d), 32'(ST_RXF_OVR));
        sdr_read(d);
        check("ov_rd0", 32'(d), 32'h01);
        sdr_read(d);
        check("ov_rd1", 32'(d), 32'h02);
        sdr_read(d);
        check("ov_rd2", 32'(d), 32'h04);
        sdr_read(d);
        check("ov_rd3", 32'(d), 32'h08);
        sdr_read(d);
        check("ov_rd_empty", 32'(d), 32'h08);
        stat_read(d);
        check("ov_status_clr", 32'(d), 32'(ST_IDLE));

        // read strobe with wr high returns zero
        sdr_sel = 1'b1;
        rd      = 1'b1;
        wr      = 1'b1;
        #1;
        check("rd_with_wr", 32'(data_out), 32'd0);
        tick();
        sdr_sel = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
